// File: rtl/dac_frame_writer.sv
// Frame buffer plus serial DAC streamer: plays N_SAMPLES words as 16-bit SYNC/SCLK/DIN transfers.
// Define DAC_OFFSET_BINARY_EN to send two's-complement samples as offset binary (MSB inverted).
module dac_frame_writer #(
  parameter int N_SAMPLES  = 256,
  parameter int DATA_W     = 12,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 2500
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(N_SAMPLES)-1:0] wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         dac_sclk,
  output logic                         dac_sync_n,
  output logic                         dac_din
);

  localparam int AW      = $clog2(N_SAMPLES);
  localparam int FRAME_W = 16;
  localparam int PAD_W   = FRAME_W - DATA_W;
  localparam int PH_W    = $clog2(2 * CLK_DIV);
  localparam int PC_W    = $clog2(SAMPLE_DIV);

  localparam logic [PH_W-1:0] PH_BIT_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_GAP_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF     = PH_W'(CLK_DIV);
  localparam logic [PC_W-1:0] PC_LAST     = PC_W'(SAMPLE_DIV - 1);
  localparam logic [AW-1:0]   IDX_LAST    = AW'(N_SAMPLES - 1);
  localparam logic [3:0]      BIT_LAST    = 4'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [PC_W-1:0]    per_q, per_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [3:0]         bit_q, bit_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sclk_q, sclk_d;
  logic               sync_n_q, sync_n_d;
  logic               din_q, din_d;

  logic [DATA_W-1:0]  mem [N_SAMPLES];
  logic [DATA_W-1:0]  rd_mem_q;
  logic [DATA_W-1:0]  fwd_data_q;
  logic               fwd_q;
  logic               wr_ok;
  logic [DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]  sample_tx;

  assign wr_ok = wr_en && !busy_q;

  // Read address follows idx_d so the word is ready in LOAD; a same-cycle write is forwarded.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    rd_mem_q   <= mem[idx_d];
    fwd_q      <= wr_ok && (wr_addr == idx_d);
    fwd_data_q <= wr_data;
  end

  assign rd_data = fwd_q ? fwd_data_q : rd_mem_q;

  always_comb begin
    sample_tx = rd_data;
`ifdef DAC_OFFSET_BINARY_EN
    sample_tx[DATA_W-1] = ~rd_data[DATA_W-1];
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    per_d   = per_q + 1'b1;
    ph_d    = ph_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        per_d = '0;
        if (start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_d = {{PAD_W{1'b0}}, sample_tx};
        ph_d    = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (ph_q == PH_BIT_LAST) begin
          ph_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_GAP: begin
        if (ph_q == PH_GAP_LAST) begin
          ph_d    = '0;
          state_d = (idx_q == IDX_LAST) ? S_DONE : S_WAIT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (per_q >= PC_LAST) begin
          per_d   = '0;
          idx_d   = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line levels are decoded from the next state so every output comes straight from a flop.
  always_comb begin
    busy_d   = (state_d == S_LOAD) || (state_d == S_SHIFT) ||
               (state_d == S_GAP)  || (state_d == S_WAIT);
    done_d   = (state_d == S_DONE);
    sync_n_d = (state_d != S_SHIFT);
    sclk_d   = !((state_d == S_SHIFT) && (ph_d >= PH_HALF));
    din_d    = (state_d == S_SHIFT) ? shift_d[FRAME_W-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      per_q    <= '0;
      ph_q     <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclk_q   <= 1'b1;
      sync_n_q <= 1'b1;
      din_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      per_q    <= per_d;
      ph_q     <= ph_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sclk_q   <= sclk_d;
      sync_n_q <= sync_n_d;
      din_q    <= din_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_n_q;
  assign dac_din    = din_q;

endmodule
